// File: rtl/processor_pkg.sv
// Shared encodings and field helpers for the processor core.
// Optional build macro: PROCESSOR_HALT_EN (enables opcode 0x3F as HALT).
package processor_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  function automatic logic [5:0] f_op(input logic [31:0] ins);
    return ins[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ins);
    return ins[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ins);
    return ins[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ins);
    return ins[15:11];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] ins);
    return ins[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] ins);
    return ins[15:0];
  endfunction

  function automatic logic [25:0] f_addr(input logic [31:0] ins);
    return ins[25:0];
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational 32-bit ALU for the processor core: add/sub/and/or/signed slt.
module processor_alu
  import processor_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  alu_op_t                  op,
  output logic signed [DATA_W-1:0] result,
  output logic                     zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, (a < b)};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/processor.sv
// Two-stage MIPS-subset core: fetch drives pc, execute commits the returned word.
// Optional build macro: PROCESSOR_HALT_EN (opcode 0x3F halts until reset).
module processor
  import processor_pkg::*;
#(
  parameter int          DMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction
);

  localparam int          ADDR_W  = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DMEM_DEPTH);

  logic                exec_valid;
  logic [31:0]         exec_pc;
  logic signed [31:0]  regs [32];
  logic signed [31:0]  dmem [DMEM_DEPTH];

  logic [5:0]          op;
  logic [5:0]          funct;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic signed [31:0]  rs_val;
  logic signed [31:0]  rt_val;
  logic signed [31:0]  imm_sx;
  logic signed [31:0]  alu_b;
  logic signed [31:0]  alu_res;
  logic                alu_zero;
  alu_op_t             alu_op;
  logic [31:0]         ea;
  logic [ADDR_W-1:0]   dmem_addr;

  logic                wr_en;
  logic [4:0]          wr_addr;
  logic signed [31:0]  wr_data;
  logic                mem_we;
  logic                redirect;
  logic [31:0]         target;
  logic                stall;

  assign op     = f_op(instruction);
  assign funct  = f_funct(instruction);
  assign rs     = f_rs(instruction);
  assign rt     = f_rt(instruction);
  assign rd     = f_rd(instruction);
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];
  assign imm_sx = {{16{instruction[15]}}, f_imm(instruction)};

  // ALU operand/operation select
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = rt_val;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_b = imm_sx;
      OP_BEQ:  alu_op = ALU_SUB;
      default: alu_op = ALU_ADD;
    endcase
  end

  processor_alu #(.DATA_W(32)) u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign ea        = alu_res;
  assign dmem_addr = ADDR_W'(ea % DEPTH_U);

`ifdef PROCESSOR_HALT_EN
  logic halt_hit;
  logic halted;
`endif

  // Commit decode: nothing commits while the execute slot holds a bubble
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = rd;
    wr_data  = alu_res;
    mem_we   = 1'b0;
    redirect = 1'b0;
    target   = exec_pc + 32'd1 + imm_sx;
`ifdef PROCESSOR_HALT_EN
    halt_hit = 1'b0;
`endif
    if (exec_valid) begin
      case (op)
        OP_RTYPE: begin
          case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: wr_en = 1'b1;
            default: wr_en = 1'b0;
          endcase
        end
        OP_ADDI: begin
          wr_en   = 1'b1;
          wr_addr = rt;
        end
        OP_LW: begin
          wr_en   = 1'b1;
          wr_addr = rt;
          wr_data = dmem[dmem_addr];
        end
        OP_SW:  mem_we   = 1'b1;
        OP_BEQ: redirect = alu_zero;
        OP_J: begin
          redirect = 1'b1;
          target   = {exec_pc[31:26], f_addr(instruction)};
        end
`ifdef PROCESSOR_HALT_EN
        OP_HALT: halt_hit = 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef PROCESSOR_HALT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) halted <= 1'b0;
    else if (halt_hit) halted <= 1'b1;
  end
  assign stall = halted | halt_hit;
`else
  assign stall = 1'b0;
`endif

  // Fetch -> execute boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      exec_valid <= 1'b0;
      exec_pc    <= '0;
    end else begin
      exec_pc <= pc;
      if (stall) begin
        exec_valid <= 1'b0;
      end else if (redirect) begin
        pc         <= target;
        exec_valid <= 1'b0;
      end else begin
        pc         <= pc + 32'd1;
        exec_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) dmem[dmem_addr] <= rt_val;
  end

endmodule

// File: tb/tb_processor.sv
// Directed-vector bench for the processor core with a one-cycle-latency instruction memory.
module tb_processor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] imem [64];
  logic [31:0] fetch_pc;
  int          tests = 0;
  int          fails = 0;

  processor #(.DMEM_DEPTH(64), .RESET_PC(32'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instruction (instruction)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) fetch_pc <= 32'd0;
    else fetch_pc <= pc;
  end
  assign instruction = imem[fetch_pc[5:0]];

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] addr);
    return {6'h02, addr};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  task automatic start();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_arith();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    imem[3] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
    imem[4] = enc_r(5'd4, 5'd1, 5'd5, 6'h2A);
    imem[5] = enc_r(5'd1, 5'd2, 5'd7, 6'h24);
    imem[6] = enc_r(5'd1, 5'd2, 5'd8, 6'h25);
    imem[7] = enc_r(5'd1, 5'd4, 5'd9, 6'h2A);
    imem[8] = enc_r(5'd1, 5'd2, 5'd10, 6'h21);
  endtask

  task automatic test_reset();
    int nz;
    #1 reset = 1'b0;
    clear_imem();
    @(negedge clk);
    tests++;
    if (pc !== 32'd0) begin fails++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
    tests++;
    if (dut.exec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", dut.exec_valid); end
    start();
    tests++;
    if (pc !== 32'd0) begin fails++; $display("FAIL release_pc: got %h expected 0", pc); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++;
      if (pc !== 32'(k)) begin fails++; $display("FAIL pc_count[%0d]: got %h expected %h", k, pc, 32'(k)); end
    end
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'h0) nz++;
    tests++;
    if (nz != 0) begin fails++; $display("FAIL reset_regs: got %0d nonzero expected 0", nz); end
  endtask

  task automatic test_arith();
    int          chk_r [8];
    logic [31:0] chk_v [8];
    chk_r = '{2, 3, 4, 5, 7, 8, 9, 10};
    chk_v = '{32'd7, 32'd12, 32'hFFFF_FFFE, 32'd1, 32'd5, 32'd7, 32'd0, 32'd0};
    reset = 1'b0;
    load_arith();
    start();
    @(negedge clk);
    tests++;
    if (dut.regs[1] !== 32'd0) begin fails++; $display("FAIL early_commit: got %h expected 0", dut.regs[1]); end
    @(negedge clk);
    tests++;
    if (dut.regs[1] !== 32'd5) begin fails++; $display("FAIL first_commit: got %h expected 5", dut.regs[1]); end
    repeat (12) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (dut.regs[chk_r[i]] !== chk_v[i]) begin
        fails++;
        $display("FAIL arith_r%0d: got %h expected %h", chk_r[i], dut.regs[chk_r[i]], chk_v[i]);
      end
    end
  endtask

  task automatic test_mem();
    int          chk_r [5];
    logic [31:0] chk_v [5];
    chk_r = '{6, 0, 10, 11, 13};
    chk_v = '{32'd9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    reset = 1'b0;
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd3);
    imem[2] = enc_i(6'h23, 5'd0, 5'd6, 16'd3);
    imem[3] = enc_i(6'h08, 5'd0, 5'd0, 16'd4);
    imem[4] = enc_i(6'h08, 5'd0, 5'd10, 16'hFFFF);
    imem[5] = enc_i(6'h2B, 5'd0, 5'd10, 16'd67);
    imem[6] = enc_i(6'h23, 5'd0, 5'd11, 16'd3);
    imem[7] = enc_i(6'h08, 5'd0, 5'd12, 16'd5);
    imem[8] = enc_i(6'h23, 5'd12, 5'd13, 16'hFFFE);
    start();
    repeat (14) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (dut.regs[chk_r[i]] !== chk_v[i]) begin
        fails++;
        $display("FAIL mem_r%0d: got %h expected %h", chk_r[i], dut.regs[chk_r[i]], chk_v[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] seq [10];
    int          chk_r [4];
    logic [31:0] chk_v [4];
    seq   = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd8, 32'd9, 32'd10, 32'd11};
    chk_r = '{3, 4, 5, 6};
    chk_v = '{32'd3, 32'd0, 32'd8, 32'd9};
    reset = 1'b0;
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    imem[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd10);
    imem[3] = enc_i(6'h08, 5'd0, 5'd3, 16'd3);
    imem[4] = enc_i(6'h04, 5'd0, 5'd0, 16'd3);
    imem[5] = enc_i(6'h08, 5'd0, 5'd4, 16'd4);
    imem[6] = enc_i(6'h08, 5'd0, 5'd4, 16'd6);
    imem[7] = enc_i(6'h08, 5'd0, 5'd4, 16'd7);
    imem[8] = enc_i(6'h08, 5'd0, 5'd5, 16'd8);
    imem[9] = enc_i(6'h08, 5'd0, 5'd6, 16'd9);
    start();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      tests++;
      if (pc !== seq[k]) begin fails++; $display("FAIL beq_pc[%0d]: got %h expected %h", k, pc, seq[k]); end
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (dut.regs[chk_r[i]] !== chk_v[i]) begin
        fails++;
        $display("FAIL beq_r%0d: got %h expected %h", chk_r[i], dut.regs[chk_r[i]], chk_v[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] seq [8];
    int          chk_r [4];
    logic [31:0] chk_v [4];
    seq   = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd16, 32'd17, 32'd18, 32'd19};
    chk_r = '{1, 2, 3, 4};
    chk_v = '{32'd1, 32'd0, 32'd3, 32'd4};
    reset = 1'b0;
    clear_imem();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[2]  = enc_j(26'h10);
    imem[3]  = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    imem[16] = enc_i(6'h08, 5'd0, 5'd3, 16'd3);
    imem[17] = enc_i(6'h08, 5'd0, 5'd4, 16'd4);
    start();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      tests++;
      if (pc !== seq[k]) begin fails++; $display("FAIL j_pc[%0d]: got %h expected %h", k, pc, seq[k]); end
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (dut.regs[chk_r[i]] !== chk_v[i]) begin
        fails++;
        $display("FAIL j_r%0d: got %h expected %h", chk_r[i], dut.regs[chk_r[i]], chk_v[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int nz;
    reset = 1'b0;
    load_arith();
    start();
    repeat (8) @(negedge clk);
    tests++;
    if (dut.regs[3] !== 32'd12) begin fails++; $display("FAIL pre_reset_r3: got %h expected %h", dut.regs[3], 32'd12); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (pc !== 32'd0) begin fails++; $display("FAIL async_pc: got %h expected 0", pc); end
    tests++;
    if (dut.exec_valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b expected 0", dut.exec_valid); end
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'h0) nz++;
    tests++;
    if (nz != 0) begin fails++; $display("FAIL async_regs: got %0d nonzero expected 0", nz); end
  endtask

  task automatic test_halt_op();
    reset = 1'b0;
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    imem[6] = {6'h3F, 5'd1, 5'd5, 16'd7};
    imem[7] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
    imem[8] = enc_i(6'h08, 5'd0, 5'd3, 16'd3);
    start();
    repeat (20) @(negedge clk);
    tests++;
    if (dut.regs[1] !== 32'd1) begin fails++; $display("FAIL op3f_r1: got %h expected 1", dut.regs[1]); end
    tests++;
    if (dut.regs[5] !== 32'd0) begin fails++; $display("FAIL op3f_r5: got %h expected 0", dut.regs[5]); end
`ifdef PROCESSOR_HALT_EN
    tests++;
    if (pc !== 32'd7) begin fails++; $display("FAIL halt_pc: got %h expected 7", pc); end
    tests++;
    if (dut.regs[2] !== 32'd0) begin fails++; $display("FAIL halt_r2: got %h expected 0", dut.regs[2]); end
    repeat (5) @(negedge clk);
    tests++;
    if (pc !== 32'd7) begin fails++; $display("FAIL halt_pc_hold: got %h expected 7", pc); end
    tests++;
    if (dut.exec_valid !== 1'b0) begin fails++; $display("FAIL halt_valid: got %b expected 0", dut.exec_valid); end
`else
    tests++;
    if (pc !== 32'd20) begin fails++; $display("FAIL nop3f_pc: got %h expected %h", pc, 32'd20); end
    tests++;
    if (dut.regs[2] !== 32'd2) begin fails++; $display("FAIL nop3f_r2: got %h expected 2", dut.regs[2]); end
    tests++;
    if (dut.regs[3] !== 32'd3) begin fails++; $display("FAIL nop3f_r3: got %h expected 3", dut.regs[3]); end
`endif
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mem();
    test_branch();
    test_jump();
    test_async_reset();
    test_halt_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
